// File: rtl/irled_pkg.sv
// Shared types and constants for the IR LED PWM sequencer.
// Holds the FSM state encoding, the segment record and the ramp step helper.
package irled_pkg;

    // Width of the drive-current select code.
    localparam int CBIT_W = 10;

    // Segment length storage width; the DUR_W parameter of the top must not exceed this.
    localparam int SEG_LEN_MAX_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WARM  = 2'd1,
        RUN   = 2'd2,
        STALL = 2'd3
    } irled_state_e;

    // One mark/space segment as held in the holding register and the active slot.
    typedef struct packed {
        logic                     mark;
        logic [SEG_LEN_MAX_W-1:0] len;
        logic                     last;
    } irled_seg_t;

    // Soft-start ramp: fill one more current bit from the bottom, saturating at all ones.
    function automatic logic [CBIT_W-1:0] ramp_step(input logic [CBIT_W-1:0] r);
        return {r[CBIT_W-2:0], 1'b1};
    endfunction

endpackage

// File: rtl/irled_carrier_gen.sv
// Carrier period/duty counter for the IR LED sequencer.
// The counter runs 0..P-1 (P = max(cfg_period,1)) while run is high and sits at 0
// otherwise. Period and duty are taken live at cnt==0 and frozen for the rest of
// the period so that register writes never produce a partial carrier pulse.
module irled_carrier_gen #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_duty,
    output logic             carrier,
    output logic             wrap
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] p_lat;
    logic [CNT_W-1:0] d_lat;
    logic [CNT_W-1:0] p_live;
    logic [CNT_W-1:0] p_eff;
    logic [CNT_W-1:0] d_eff;

    // Effective period/duty: live values at the start of a period, latched copies afterwards.
    always_comb begin
        p_live  = (cfg_period == '0) ? ONE : cfg_period;
        p_eff   = (cnt == '0) ? p_live : p_lat;
        d_eff   = (cnt == '0) ? cfg_duty : d_lat;
        carrier = (cnt < d_eff);
        wrap    = run && (cnt == (p_eff - ONE));
    end

    // Period counter and the configuration snapshot taken at cnt==0.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            p_lat <= '0;
            d_lat <= '0;
        end else begin
            if (!run || wrap) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + ONE;
            end
            if (run && (cnt == '0)) begin
                p_lat <= p_live;
                d_lat <= cfg_duty;
            end
        end
    end

endmodule

// File: rtl/irled_pwm_seq.sv
// IR LED PWM sequencer: turns a stream of mark/space segments into the gated
// carrier, the bias enable and the drive-current code for the IR pad driver.
// Optional build macro: IRLED_SOFTSTART_EN (drive current ramps up one bit per
// carrier period after warm-up instead of jumping straight to cfg_strength).
//
// Segment handshake: seg_ready = enable & !hold_valid. A segment is transferred on
// any rising clk edge where seg_valid & seg_ready are both high; the producer must
// hold seg_mark/seg_len/seg_last stable while seg_valid is high and not yet taken.
module irled_pwm_seq
    import irled_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int DUR_W    = 16,
    parameter int WARM_CYC = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [CNT_W-1:0]  cfg_duty,
    input  logic [CBIT_W-1:0] cfg_strength,
    input  logic              seg_valid,
    output logic              seg_ready,
    input  logic              seg_mark,
    input  logic [DUR_W-1:0]  seg_len,
    input  logic              seg_last,
    output logic              ir_pwm,
    output logic              irled_en,
    output logic [CBIT_W-1:0] cbit_ir,
    output logic              busy,
    output logic              done,
    output logic              underrun
);

    localparam int WARM_W = (WARM_CYC > 1) ? $clog2(WARM_CYC) : 1;
    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARM_CYC - 1);
    localparam logic [SEG_LEN_MAX_W-1:0] LEN_ONE = SEG_LEN_MAX_W'(1);

    irled_state_e state;
    irled_state_e state_nxt;
    irled_state_e pop_state;

    logic              hold_valid;
    irled_seg_t        hold;
    irled_seg_t        act;
    logic [WARM_W-1:0] warm_cnt;
    logic              enable_q;

    logic              run;
    logic              carrier;
    logic              wrap;
    logic              push;
    logic              pop;
    logic              pop_done;
    logic              seg_end;
    logic              done_nxt;
    logic              underrun_set;
    logic [CBIT_W-1:0] cbit_mask;

    assign seg_ready = enable && !hold_valid;
    assign push      = seg_valid && seg_ready;
    assign run       = enable && (state == RUN);
    assign seg_end   = (state == RUN) && wrap && (act.len == LEN_ONE);

    irled_carrier_gen #(
        .CNT_W(CNT_W)
    ) u_carrier (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .cfg_period(cfg_period),
        .cfg_duty  (cfg_duty),
        .carrier   (carrier),
        .wrap      (wrap)
    );

    // Where a pop from the holding register leads: a zero-length segment is
    // discarded on the spot, finishing the frame if it is the last one and
    // otherwise waiting in STALL for the next segment.
    always_comb begin
        if (hold.len != '0) begin
            pop_state = RUN;
            pop_done  = 1'b0;
        end else if (hold.last) begin
            pop_state = IDLE;
            pop_done  = 1'b1;
        end else begin
            pop_state = STALL;
            pop_done  = 1'b0;
        end
    end

    // Next-state decisions: pops, frame completion and underrun detection.
    always_comb begin
        state_nxt    = state;
        pop          = 1'b0;
        done_nxt     = 1'b0;
        underrun_set = 1'b0;
        case (state)
            IDLE: begin
                if (hold_valid) begin
                    state_nxt = WARM;
                end
            end
            WARM: begin
                if (warm_cnt == WARM_LAST) begin
                    pop       = 1'b1;
                    state_nxt = pop_state;
                    done_nxt  = pop_done;
                end
            end
            RUN: begin
                if (seg_end) begin
                    if (act.last) begin
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end else if (hold_valid) begin
                        pop       = 1'b1;
                        state_nxt = pop_state;
                        done_nxt  = pop_done;
                    end else begin
                        underrun_set = 1'b1;
                        state_nxt    = STALL;
                    end
                end
            end
            STALL: begin
                if (hold_valid) begin
                    pop       = 1'b1;
                    state_nxt = pop_state;
                    done_nxt  = pop_done;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Dropping enable abandons the frame silently from any state.
        if (!enable) begin
            state_nxt    = IDLE;
            pop          = 1'b0;
            done_nxt     = 1'b0;
            underrun_set = 1'b0;
        end
    end

`ifdef IRLED_SOFTSTART_EN
    logic [CBIT_W-1:0] ramp;
    logic [CBIT_W-1:0] ramp_nxt;

    // Ramp restarts at one bit on entry to WARM and gains a bit per carrier wrap.
    always_comb begin
        ramp_nxt = ramp;
        if ((state_nxt == WARM) && (state != WARM)) begin
            ramp_nxt = CBIT_W'(1);
        end else if ((state == RUN) && wrap) begin
            ramp_nxt = ramp_step(ramp);
        end
    end

    // Ramp register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ramp <= '0;
        end else begin
            ramp <= ramp_nxt;
        end
    end

    assign cbit_mask = ramp_nxt;
`else
    assign cbit_mask = '1;
`endif

    // FSM state, holding register, active segment and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            hold_valid <= 1'b0;
            hold       <= '0;
            act        <= '0;
            warm_cnt   <= '0;
            enable_q   <= 1'b0;
            ir_pwm     <= 1'b0;
            irled_en   <= 1'b0;
            cbit_ir    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            state    <= state_nxt;
            enable_q <= enable;
            done     <= done_nxt;

            // A push always wins over a pop so the new segment is kept.
            if (!enable) begin
                hold_valid <= 1'b0;
            end else if (push) begin
                hold_valid <= 1'b1;
            end else if (pop) begin
                hold_valid <= 1'b0;
            end
            if (push) begin
                hold <= '{mark: seg_mark, len: SEG_LEN_MAX_W'(seg_len), last: seg_last};
            end

            // Remaining length counts down at each wrap; it is checked for 1
            // before decrementing so it never goes below 1 while active.
            if (pop) begin
                act <= hold;
            end else if ((state == RUN) && wrap && (act.len > LEN_ONE)) begin
                act.len <= act.len - LEN_ONE;
            end

            if ((state == WARM) && (state_nxt == WARM)) begin
                warm_cnt <= warm_cnt + WARM_W'(1);
            end else begin
                warm_cnt <= '0;
            end

            if (underrun_set) begin
                underrun <= 1'b1;
            end else if (enable && !enable_q) begin
                underrun <= 1'b0;
            end

            ir_pwm   <= run && carrier && act.mark;
            irled_en <= (state_nxt != IDLE);
            busy     <= (state_nxt != IDLE);
            cbit_ir  <= (state_nxt == IDLE) ? '0 : (cfg_strength & cbit_mask);
        end
    end

endmodule

// File: tb/tb_irled_pwm_seq.sv
// Self-checking bench for irled_pwm_seq (default build, WARM_CYC = 64).
// Table of single-segment frames plus hand-written multi-segment, underrun,
// abort and reset sequences.
module tb_irled_pwm_seq;

    localparam int CNT_W = 16;
    localparam int DUR_W = 16;
    localparam int WARM  = 64;

    logic             clk;
    logic             rst;
    logic             enable;
    logic [CNT_W-1:0] cfg_period;
    logic [CNT_W-1:0] cfg_duty;
    logic [9:0]       cfg_strength;
    logic             seg_valid;
    logic             seg_ready;
    logic             seg_mark;
    logic [DUR_W-1:0] seg_len;
    logic             seg_last;
    logic             ir_pwm;
    logic             irled_en;
    logic [9:0]       cbit_ir;
    logic             busy;
    logic             done;
    logic             underrun;

    irled_pwm_seq #(
        .CNT_W   (CNT_W),
        .DUR_W   (DUR_W),
        .WARM_CYC(WARM)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .cfg_period  (cfg_period),
        .cfg_duty    (cfg_duty),
        .cfg_strength(cfg_strength),
        .seg_valid   (seg_valid),
        .seg_ready   (seg_ready),
        .seg_mark    (seg_mark),
        .seg_len     (seg_len),
        .seg_last    (seg_last),
        .ir_pwm      (ir_pwm),
        .irled_en    (irled_en),
        .cbit_ir     (cbit_ir),
        .busy        (busy),
        .done        (done),
        .underrun    (underrun)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Segment feeder: presents queued segments and retires one per accepted handshake.
    typedef struct {
        logic             mark;
        logic [DUR_W-1:0] len;
        logic             last;
    } seg_t;

    seg_t feed_q[$];
    logic fire;

    always begin
        @(negedge clk);
        fire = seg_valid && seg_ready;
        @(posedge clk);
        #1;
        if (fire && (feed_q.size() > 0)) void'(feed_q.pop_front());
        if (feed_q.size() > 0) begin
            seg_valid = 1'b1;
            seg_mark  = feed_q[0].mark;
            seg_len   = feed_q[0].len;
            seg_last  = feed_q[0].last;
        end else begin
            seg_valid = 1'b0;
        end
    end

    function automatic seg_t mk_seg(input logic m, input int l, input logic la);
        seg_t s;
        s.mark = m;
        s.len  = DUR_W'(l);
        s.last = la;
        return s;
    endfunction

    // Frame recorder: collects ir_pwm from the first irled_en sample to the done sample.
    bit         trace[$];
    int         en_cnt;
    int         done_cnt;
    logic [9:0] cbit_first;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic record_frame(input int budget, output bit ok);
        bit seen;
        seen       = 1'b0;
        ok         = 1'b0;
        en_cnt     = 0;
        done_cnt   = 0;
        cbit_first = '0;
        trace.delete();
        for (int c = 0; c < budget; c++) begin
            tick();
            if (irled_en || done) trace.push_back(ir_pwm);
            if (irled_en) en_cnt++;
            if (irled_en && !seen) begin
                seen       = 1'b1;
                cbit_first = cbit_ir;
            end
            if (done) begin
                done_cnt++;
                ok = 1'b1;
                break;
            end
        end
    endtask

    function automatic int trace_high();
        int h = 0;
        foreach (trace[i]) h += int'(trace[i]);
        return h;
    endfunction

    function automatic logic [31:0] trace_pat(input int n);
        logic [31:0] p = '0;
        for (int i = 0; (i < n) && (i < 32); i++) begin
            if ((WARM + 1 + i) < trace.size()) p[i] = trace[WARM + 1 + i];
        end
        return p;
    endfunction

    typedef struct {
        logic [CNT_W-1:0] period;
        logic [CNT_W-1:0] duty;
        logic             mark;
        int               len;
        logic [9:0]       strength;
        int               exp_run;
        int               exp_high;
        logic [31:0]      exp_pat;
    } vec_t;

    vec_t vecs[8];

    task automatic check_idle(input string tag);
        check({tag, "_ir_pwm"}, 32'(ir_pwm), 32'd0);
        check({tag, "_irled_en"}, 32'(irled_en), 32'd0);
        check({tag, "_cbit_ir"}, 32'(cbit_ir), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        bit ok;
        int cnt;

        // Table: period, duty, mark, len, strength, run clocks, high clocks, ir_pwm pattern
        vecs[0] = '{16'd4, 16'd2, 1'b1, 3, 10'h3FF, 12, 6, 32'h333};
        vecs[1] = '{16'd4, 16'd0, 1'b1, 2, 10'h155, 8, 0, 32'h0};
        vecs[2] = '{16'd4, 16'd7, 1'b1, 2, 10'h0AA, 8, 8, 32'hFF};
        vecs[3] = '{16'd0, 16'd1, 1'b1, 3, 10'h3FF, 3, 3, 32'h7};
        vecs[4] = '{16'd3, 16'd1, 1'b0, 2, 10'h001, 6, 0, 32'h0};
        vecs[5] = '{16'd5, 16'd3, 1'b1, 1, 10'h200, 5, 3, 32'h07};
        vecs[6] = '{16'd1, 16'd0, 1'b1, 4, 10'h3FF, 4, 0, 32'h0};
        vecs[7] = '{16'd4, 16'd2, 1'b1, 0, 10'h3FF, 0, 0, 32'h0};

        // Reset
        rst          = 1'b1;
        enable       = 1'b0;
        cfg_period   = '0;
        cfg_duty     = '0;
        cfg_strength = '0;
        seg_valid    = 1'b0;
        seg_mark     = 1'b0;
        seg_len      = '0;
        seg_last     = 1'b0;
        repeat (3) tick();
        check_idle("reset");
        check("reset_underrun", 32'(underrun), 32'd0);
        check("reset_ready_disabled", 32'(seg_ready), 32'd0);
        rst    = 1'b0;
        enable = 1'b1;
        #1;
        check("ready_after_enable", 32'(seg_ready), 32'd1);
        tick();

        // Single-segment frames
        foreach (vecs[v]) begin
            cfg_period   = vecs[v].period;
            cfg_duty     = vecs[v].duty;
            cfg_strength = vecs[v].strength;
            feed_q.push_back(mk_seg(vecs[v].mark, vecs[v].len, 1'b1));
            record_frame(400, ok);
            check($sformatf("v%0d_done_seen", v), 32'(ok), 32'd1);
            check($sformatf("v%0d_frame_len", v), 32'(trace.size()), 32'(WARM + 1 + vecs[v].exp_run));
            check($sformatf("v%0d_en_clocks", v), 32'(en_cnt), 32'(WARM + vecs[v].exp_run));
            check($sformatf("v%0d_high", v), 32'(trace_high()), 32'(vecs[v].exp_high));
            check($sformatf("v%0d_pattern", v), trace_pat(vecs[v].exp_run), vecs[v].exp_pat);
            check($sformatf("v%0d_cbit", v), 32'(cbit_first), 32'(vecs[v].strength));
            tick();
            check_idle($sformatf("v%0d_after", v));
            check($sformatf("v%0d_underrun", v), 32'(underrun), 32'd0);
        end

        // Back-to-back mark3, space2, mark1(last): no gaps, no underrun
        cfg_period   = 16'd4;
        cfg_duty     = 16'd2;
        cfg_strength = 10'h3FF;
        feed_q.push_back(mk_seg(1'b1, 3, 1'b0));
        feed_q.push_back(mk_seg(1'b0, 2, 1'b0));
        feed_q.push_back(mk_seg(1'b1, 1, 1'b1));
        record_frame(400, ok);
        check("multi_done_seen", 32'(ok), 32'd1);
        check("multi_done_count", 32'(done_cnt), 32'd1);
        check("multi_frame_len", 32'(trace.size()), 32'(WARM + 1 + 24));
        check("multi_high", 32'(trace_high()), 32'd8);
        check("multi_pattern", trace_pat(24), 32'h300333);
        check("multi_underrun", 32'(underrun), 32'd0);
        tick();
        check_idle("multi_after");

        // Underrun: mark2 without last, then space1 last resumes from STALL
        feed_q.push_back(mk_seg(1'b1, 2, 1'b0));
        cnt = 0;
        ok  = 1'b0;
        for (int c = 0; c < 300; c++) begin
            tick();
            if (irled_en) cnt++;
            if (underrun) begin
                ok = 1'b1;
                break;
            end
        end
        check("underrun_seen", 32'(ok), 32'd1);
        check("underrun_timing", 32'(cnt), 32'(WARM + 8 + 1));
        check("stall_irled_en", 32'(irled_en), 32'd1);
        check("stall_busy", 32'(busy), 32'd1);
        cnt = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            cnt += int'(ir_pwm) + int'(done) + int'(!irled_en);
        end
        check("stall_quiet", 32'(cnt), 32'd0);
        feed_q.push_back(mk_seg(1'b0, 1, 1'b1));
        record_frame(100, ok);
        check("resume_done_seen", 32'(ok), 32'd1);
        check("resume_high", 32'(trace_high()), 32'd0);
        check("resume_underrun_sticky", 32'(underrun), 32'd1);

        // Abort mid-RUN with a second segment waiting in the holding register
        feed_q.push_back(mk_seg(1'b1, 10, 1'b0));
        feed_q.push_back(mk_seg(1'b1, 10, 1'b1));
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            tick();
            if (ir_pwm) begin
                ok = 1'b1;
                break;
            end
        end
        check("abort_pwm_seen", 32'(ok), 32'd1);
        repeat (4) tick();
        check("abort_queue_taken", 32'(feed_q.size()), 32'd0);
        enable = 1'b0;
        #1;
        check("abort_ready_low", 32'(seg_ready), 32'd0);
        tick();
        check_idle("abort");
        check("abort_underrun_kept", 32'(underrun), 32'd1);
        cnt = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            cnt += int'(done) + int'(seg_ready);
        end
        check("abort_no_done", 32'(cnt), 32'd0);
        enable = 1'b1;
        tick();
        check("enable_rise_clears_underrun", 32'(underrun), 32'd0);
        cnt = 0;
        for (int c = 0; c < 80; c++) begin
            tick();
            cnt += int'(irled_en) + int'(busy);
        end
        check("abort_hold_flushed", 32'(cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/irled_pwm_seq.md
Name: irled_pwm_seq

Overview:
- Sequencer that feeds the IR LED pad driver: produces the `ir_pwm` carrier, the `irled_en` bias enable and the `cbit_ir[9:0]` current-select code.
- Consumes a stream of mark/space segments, with durations counted in carrier periods. During marks it gates a programmable carrier (e.g. 38 kHz); during spaces it holds the carrier low.
- Sits between the register/stream interface and the IR bias plus pad-driver macro.

Parameters:
CNT_W, 16, width of carrier period/duty counter (system clocks)
DUR_W, 16, width of segment length (carrier periods)
WARM_CYC, 64, clocks between irled_en rise and first carrier edge (bias settle)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
enable  in  1  block enable; low aborts any activity
cfg_period  in  CNT_W  carrier period in clocks
cfg_duty  in  CNT_W  carrier high time in clocks
cfg_strength  in  10  drive-current bits for cbit_ir
seg_valid  in  1  segment offered
seg_ready  out  1  segment accepted when valid&ready
seg_mark  in  1  1=mark (carrier on), 0=space
seg_len  in  DUR_W  segment length in carrier periods
seg_last  in  1  final segment of frame
ir_pwm  out  1  carrier to pad driver
irled_en  out  1  bias enable
cbit_ir  out  10  drive-current select
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at end of last segment
underrun  out  1  sticky: current segment ended, holding register empty, no seg_last seen

Behaviour:
- Clock/reset: one clock `clk`; reset `rst` is synchronous, active-high.
- Reset values: all outputs 0, state IDLE, counters 0, holding register empty.
- Registered outputs: all outputs are registered.
- Holding register (one entry):
  - seg_ready = enable & !hold_valid.
  - A transfer on valid&ready loads mark/len/last into the holding register on the next edge.
- FSM states: IDLE, WARM, RUN, STALL.
- IDLE:
  - irled_en=0, ir_pwm=0, cbit_ir=0.
  - Go to WARM when enable & hold_valid.
- WARM:
  - irled_en=1 from the first WARM cycle.
  - cbit_ir=cfg_strength; ir_pwm=0.
  - After WARM_CYC clocks, pop the holding register into the active segment, set cnt=0, go to RUN.
- RUN, carrier:
  - cnt counts 0..P-1, where P=max(cfg_period,1).
  - cfg_period and cfg_duty are sampled at cnt==0 only, so there is no mid-period glitch.
  - carrier = (cnt < cfg_duty); duty>=P gives constant high, duty=0 gives constant low.
  - ir_pwm = carrier & active_mark, registered: one-cycle latency from cnt.
- RUN, segment counting:
  - rem is decremented at each period wrap (cnt==P-1).
  - When rem reaches 0 at a wrap:
    - If active_last: pulse done, go to IDLE (irled_en drops the same edge).
    - Else if hold_valid: pop the next segment with no gap; cnt restarts at 0.
    - Else: set underrun, go to STALL.
- Zero-length segments: seg_len=0 is popped and discarded immediately at the pop point with zero duration. If it carries seg_last, done pulses and the block returns to IDLE.
- STALL:
  - ir_pwm=0, irled_en=1.
  - On hold_valid, pop and re-enter RUN with cnt=0.
- Abort: enable=0 in any state forces IDLE on the next edge. Holding register flushed, ir_pwm/irled_en/cbit_ir go to 0, no done pulse, underrun kept.
- underrun clear: only by reset or a rising edge of enable.
- Simultaneous pop and push: hold_valid stays 1 with the new data.
- Counter wrap: rem and cnt are unsigned and never underflow; the wrap condition is tested before decrement.

Optional Feature:
- Macro: IRLED_SOFTSTART_EN.
- Defined:
  - cbit_ir = cfg_strength & ramp.
  - ramp resets to 10'b0000000001 on entering WARM and shifts {ramp[8:0],1'b1} at each carrier wrap in RUN, until all ones.
  - Limits inrush current over the first 9 periods.
- Undefined: cbit_ir = cfg_strength throughout WARM/RUN/STALL; no ramp logic.

Decomposition:
- Package irled_pkg:
  - FSM state enum (IDLE/WARM/RUN/STALL).
  - Segment struct {mark, len, last}.
  - CBIT_W=10.
- One sub-module, irled_carrier_gen: period/duty counter with sample-at-zero and a wrap strobe.

Test Plan:
1. period=4, duty=2, strength=10'h3FF, one segment mark len=3 last → irled_en high 64 clk, then ir_pwm pattern 1100×3; done pulses once; irled_en 0 after.
2. Segments mark3, space2, mark1(last) pushed back-to-back → 12 carrier clocks of mark, 8 low, 4 mark. No gap between segments, underrun=0.
3. Only mark len=2 (not last) pushed → underrun=1, STALL with ir_pwm=0 and irled_en=1. Then push space1 last → resumes, done pulses.
4. duty=0 → ir_pwm never high. duty=7 with period=4 → ir_pwm constant high during mark. period=0 → treated as 1.
5. enable dropped mid-RUN → next edge ir_pwm=0, irled_en=0, cbit_ir=0, busy=0, no done; seg_ready=0 while enable low.
6. IRLED_SOFTSTART_EN defined, strength=10'h3FF → cbit_ir 001, 003, 007 … 3FF on successive wraps. Undefined → 3FF from WARM.
